// File: rtl/johnson_seq_ctrl_if.sv
// Handshake/status bundle for johnson_seq_ctrl: run/load controls in, counter state and status out.
// The master drives requests; the slave (the controller) drives the counter view.
interface johnson_seq_ctrl_if #(
   parameter int STEP_W = 8
);
   logic              start;
   logic [STEP_W-1:0] step_count;
   logic              dir;
   logic              pause;
   logic              load_en;
   logic [4:0]        load_val;
   logic [4:0]        q;
   logic [9:0]        phase;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, step_count, dir, pause, load_en, load_val,
      input  q, phase, busy, done, err
   );

   modport slave (
      input  start, step_count, dir, pause, load_en, load_val,
      output q, phase, busy, done, err
   );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Johnson-counter sequencer that runs a requested number of forward/reverse steps with pause/preload.
// Optional JSC_ILLEGAL_RECOVER_EN forces illegal counter states back to zero and raises a sticky err.
module johnson_seq_ctrl #(
   parameter int STEP_W = 8
) (
   input logic                        clk,
   input logic                        rst_n,
   johnson_seq_ctrl_if.slave          bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_nx;
   logic [4:0]        q_q, q_nx;
   logic [STEP_W-1:0] rem_q, rem_nx;
   logic              dir_q, dir_nx;
   logic [9:0]        phase_dec;
   logic              start_ok;

   // One Johnson step; reverse shifts right and feeds back the inverted LSB.
   function automatic logic [4:0] johnson_step(input logic [4:0] cur, input logic rev);
      logic [4:0] res;
      if (rev) begin
         res = {~cur[0], cur[4:1]};
      end else begin
         res = {cur[3:0], ~cur[4]};
      end
      return res;
   endfunction

   always_comb begin
      phase_dec = 10'd0;
      case (q_q)
         5'b00000: phase_dec[0] = 1'b1;
         5'b00001: phase_dec[1] = 1'b1;
         5'b00011: phase_dec[2] = 1'b1;
         5'b00111: phase_dec[3] = 1'b1;
         5'b01111: phase_dec[4] = 1'b1;
         5'b11111: phase_dec[5] = 1'b1;
         5'b11110: phase_dec[6] = 1'b1;
         5'b11100: phase_dec[7] = 1'b1;
         5'b11000: phase_dec[8] = 1'b1;
         5'b10000: phase_dec[9] = 1'b1;
         default:  phase_dec    = 10'd0;
      endcase
   end

   // A load in IDLE shadows a simultaneous start.
   assign start_ok = (state_q == IDLE) && bus.start && !bus.load_en;

   always_comb begin
      state_nx = state_q;
      q_nx     = q_q;
      rem_nx   = rem_q;
      dir_nx   = dir_q;
      case (state_q)
         IDLE: begin
            if (bus.load_en) begin
               q_nx = bus.load_val;
            end else if (bus.start) begin
               state_nx = RUN;
               rem_nx   = bus.step_count;
               dir_nx   = bus.dir;
            end
         end
         RUN: begin
            if (rem_q == '0) begin
               state_nx = DONE;
            end else if (!bus.pause) begin
               q_nx   = johnson_step(q_q, dir_q);
               rem_nx = rem_q - STEP_W'(1);
               if (rem_q == STEP_W'(1)) begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
`ifdef JSC_ILLEGAL_RECOVER_EN
      // Recovery overrides any step or load; an illegal state mid-run aborts to DONE.
      if (phase_dec == 10'd0) begin
         q_nx = 5'b00000;
         if (state_q == RUN) begin
            state_nx = DONE;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= 5'b00000;
         rem_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_nx;
         q_q     <= q_nx;
         rem_q   <= rem_nx;
         dir_q   <= dir_nx;
      end
   end

`ifdef JSC_ILLEGAL_RECOVER_EN
   logic err_q;

   // Detection wins over the clear from a start accepted on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (phase_dec == 10'd0) begin
         err_q <= 1'b1;
      end else if (start_ok) begin
         err_q <= 1'b0;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
   assign bus.err = 1'b0;
`endif

   assign bus.q     = q_q;
   assign bus.phase = phase_dec;
   assign bus.busy  = (state_q == RUN);
   assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed self-checking bench for johnson_seq_ctrl; expectations follow JSC_ILLEGAL_RECOVER_EN when defined.
module tb_johnson_seq_ctrl;
   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;

   johnson_seq_ctrl_if #(.STEP_W(8)) bus ();

   johnson_seq_ctrl #(.STEP_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [7:0] sc, input logic dr,
                                input logic ps, input logic ld, input logic [4:0] lv);
      bus.start      = st;
      bus.step_count = sc;
      bus.dir        = dr;
      bus.pause      = ps;
      bus.load_en    = ld;
      bus.load_val   = lv;
   endtask

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic checkStatus(input string tag, input logic [4:0] q, input logic busy, input logic done);
      checkOutput({tag, ".q"},    32'(bus.q),    32'(q));
      checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(busy));
      checkOutput({tag, ".done"}, 32'(bus.done), 32'(done));
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n       = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      #12;
      checkStatus("reset", 5'b00000, 1'b0, 1'b0);
      checkOutput("reset.phase", 32'(bus.phase), 32'h001);
      checkOutput("reset.err",   32'(bus.err),   32'h0);
      rst_n = 1'b1;

      // Forward run of three steps from zero
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
      stepClk();
      applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("fwd.enter", 5'b00000, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("fwd.s1", 5'b00001, 1'b1, 1'b0);
      stepClk();
      checkStatus("fwd.s2", 5'b00011, 1'b1, 1'b0);
      stepClk();
      checkStatus("fwd.s3", 5'b00111, 1'b0, 1'b1);
      checkOutput("fwd.phase", 32'(bus.phase), 32'h008);
      stepClk();
      checkStatus("fwd.idle", 5'b00111, 1'b0, 1'b0);

      // Reverse run wrapping from index 0 to 9
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
      stepClk();
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 5'b00000);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("rev.s1", 5'b10000, 1'b1, 1'b0);
      checkOutput("rev.phase1", 32'(bus.phase), 32'h200);
      stepClk();
      checkStatus("rev.s2", 5'b11000, 1'b0, 1'b1);
      checkOutput("rev.phase2", 32'(bus.phase), 32'h100);
      stepClk();

      // Pause for two cycles; dir/step_count changes mid-run are ignored
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
      stepClk();
      applyStimulus(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("pause.s1", 5'b00001, 1'b1, 1'b0);
      stepClk();
      checkStatus("pause.s2", 5'b00011, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 5'b00000);
      stepClk();
      checkStatus("pause.h1", 5'b00011, 1'b1, 1'b0);
      stepClk();
      checkStatus("pause.h2", 5'b00011, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("pause.s3", 5'b00111, 1'b1, 1'b0);
      stepClk();
      checkStatus("pause.s4", 5'b01111, 1'b0, 1'b1);
      stepClk();
      checkStatus("pause.idle", 5'b01111, 1'b0, 1'b0);

      // Zero-step run: one busy cycle, then done, q untouched
      applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("zero.run", 5'b01111, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("zero.done", 5'b01111, 1'b0, 1'b1);
      stepClk();
      checkStatus("zero.idle", 5'b01111, 1'b0, 1'b0);

      // start held through the run is not queued
      applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      stepClk();
      checkStatus("hold.s1", 5'b11111, 1'b1, 1'b0);
      stepClk();
      checkStatus("hold.s2", 5'b11110, 1'b0, 1'b1);
      stepClk();
      checkStatus("hold.back", 5'b11110, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("hold.nostart", 5'b11110, 1'b0, 1'b0);

      // Forward wrap 9->0; load_en during RUN ignored
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'b10000);
      stepClk();
      applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'b11111);
      stepClk();
      checkStatus("wrap.s1", 5'b00000, 1'b1, 1'b0);
      stepClk();
      checkStatus("wrap.s2", 5'b00001, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();

      // load and start together: load wins
      applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 5'b00011);
      stepClk();
      checkStatus("ldstart", 5'b00011, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("ldstart.idle", 5'b00011, 1'b0, 1'b0);

      // Illegal preload
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'b01010);
      stepClk();
      checkOutput("ill.q", 32'(bus.q), 32'h0A);
      checkOutput("ill.phase", 32'(bus.phase), 32'h000);
`ifdef JSC_ILLEGAL_RECOVER_EN
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkOutput("ill.recq", 32'(bus.q), 32'h00);
      checkOutput("ill.err", 32'(bus.err), 32'h1);
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkOutput("ill.errclr", 32'(bus.err), 32'h0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("ill.run", 5'b00001, 1'b0, 1'b1);
`else
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("ill.step", 5'b10101, 1'b0, 1'b1);
      checkOutput("ill.err", 32'(bus.err), 32'h0);
`endif
      stepClk();

      // Reset mid-run aborts without a done pulse
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 5'b00000);
      stepClk();
      applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      stepClk();
      checkStatus("rst.s2", 5'b00011, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkStatus("rst.async", 5'b00000, 1'b0, 1'b0);
      checkOutput("rst.phase", 32'(bus.phase), 32'h001);
      checkOutput("rst.err", 32'(bus.err), 32'h0);
      stepClk();
      checkStatus("rst.held", 5'b00000, 1'b0, 1'b0);
      rst_n = 1'b1;
      stepClk();
      checkStatus("rst.after", 5'b00000, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("rst.start", 5'b00000, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 5'b00000);
      stepClk();
      checkStatus("rst.done", 5'b00001, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
